// File: rtl/mux_8x1_if.sv
`default_nettype none
// ============================================================================
// Module : mux_8x1_if
// Brief  : Data, select and qualifier bundle for the 8:1 lane multiplexer.
// Rev    : 1.0 - initial release
// ============================================================================
interface mux_8x1_if #(
    parameter int DATA_W = 1
);
    logic [8*DATA_W-1:0] in;
    logic [2:0]          sel;
    logic                en;
    logic [DATA_W-1:0]   out;
    logic                out_valid;
    logic [7:0]          sel_onehot;

    modport master (
        output in, sel, en,
        input  out, out_valid, sel_onehot
    );

    modport slave (
        input  in, sel, en,
        output out, out_valid, sel_onehot
    );
endinterface
`default_nettype wire

// File: rtl/mux_8x1.sv
`default_nettype none
// ============================================================================
// Module : mux_8x1
// Brief  : Eight-lane selector with optional output register and one-hot tag.
// Rev    : 1.0 - initial release
// ============================================================================
module mux_8x1 #(
    parameter int DATA_W  = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_8x1_if.slave   bus
);

    logic [DATA_W-1:0] w_lanes [8];
    logic [DATA_W-1:0] w_lane;
    logic [7:0]        w_onehot;

    for (genvar k = 0; k < 8; k++) begin : g_lane
        assign w_lanes[k] = bus.in[k*DATA_W +: DATA_W];
    end

    always_comb begin
        w_lane   = w_lanes[bus.sel];
        w_onehot = 8'b0000_0001 << bus.sel;
    end

    if (REG_OUT) begin : g_reg
        logic [DATA_W-1:0] out_q,    out_d;
        logic [7:0]        onehot_q, onehot_d;
        logic              valid_q,  valid_d;

        // Data and tag hold while en is low; only the valid flag drops.
        always_comb begin
            out_d    = out_q;
            onehot_d = onehot_q;
            valid_d  = bus.en;
            if (bus.en) begin
                out_d    = w_lane;
                onehot_d = w_onehot;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q    <= '0;
                onehot_q <= '0;
                valid_q  <= 1'b0;
            end else begin
                out_q    <= out_d;
                onehot_q <= onehot_d;
                valid_q  <= valid_d;
            end
        end

        assign bus.out        = out_q;
        assign bus.sel_onehot = onehot_q;
        assign bus.out_valid  = valid_q;
    end else begin : g_comb
        // Reset only masks the qualifier; the data path stays live.
        assign bus.out        = w_lane;
        assign bus.sel_onehot = w_onehot;
        assign bus.out_valid  = bus.en & rst_n;
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_8x1.sv
`default_nettype none
// ============================================================================
// Module : tb_mux_8x1
// Brief  : Scoreboard bench for mux_8x1 (registered, combinational, wide).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mux_8x1;

    logic clk;
    logic rst_n;

    mux_8x1_if #(.DATA_W(1)) mbus ();
    mux_8x1_if #(.DATA_W(1)) cbus ();
    mux_8x1_if #(.DATA_W(4)) wbus ();

    mux_8x1 #(.DATA_W(1), .REG_OUT(1'b1)) dut   (.clk(clk), .rst_n(rst_n), .bus(mbus));
    mux_8x1 #(.DATA_W(1), .REG_OUT(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(cbus));
    mux_8x1 #(.DATA_W(4), .REG_OUT(1'b1)) dut_w (.clk(clk), .rst_n(rst_n), .bus(wbus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       o;
        logic       v;
        logic [7:0] oh;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected response for each issued vector appears one edge later.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("out",        {31'd0, mbus.out},       {31'd0, mon_e.o});
            check("out_valid",  {31'd0, mbus.out_valid}, {31'd0, mon_e.v});
            check("sel_onehot", {24'd0, mbus.sel_onehot}, {24'd0, mon_e.oh});
        end
    end

    task automatic apply(input logic [7:0] i, input logic [2:0] s, input logic e,
                         input logic eo, input logic ev, input logic [7:0] eoh);
        @(negedge clk);
        mbus.in  = i;
        mbus.sel = s;
        mbus.en  = e;
        sb.push_back('{o: eo, v: ev, oh: eoh});
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    logic       exh [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] r_in;
    logic [2:0] r_sel;

    initial begin
        rst_n = 1'b0;
        mbus.in = '0; mbus.sel = '0; mbus.en = 1'b0;
        cbus.in = '0; cbus.sel = '0; cbus.en = 1'b1;
        wbus.in = '0; wbus.sel = '0; wbus.en = 1'b0;
        #1;
        check("rst_out",    {31'd0, mbus.out},        32'd0);
        check("rst_valid",  {31'd0, mbus.out_valid},  32'd0);
        check("rst_onehot", {24'd0, mbus.sel_onehot}, 32'd0);
        check("rst_c_valid", {31'd0, cbus.out_valid}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++)
            apply(8'b1010_0110, 3'(k), 1'b1, exh[k], 1'b1, 8'b0000_0001 << k);

        for (int n = 0; n < 20; n++) begin
            r_in  = 8'($urandom);
            r_sel = 3'($urandom_range(0, 7));
            apply(r_in, r_sel, 1'b1, r_in[r_sel], 1'b1, 8'b0000_0001 << r_sel);
        end

        apply(8'hFF, 3'd3, 1'b1, 1'b1, 1'b1, 8'b0000_1000);
        apply(8'h00, 3'd3, 1'b0, 1'b1, 1'b0, 8'b0000_1000);
        apply(8'h00, 3'd6, 1'b0, 1'b1, 1'b0, 8'b0000_1000);
        apply(8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 8'b0000_1000);
        drain();

        @(negedge clk);
        wbus.in  = 32'h7654_3210;
        wbus.sel = 3'd5;
        wbus.en  = 1'b1;
        #1;
        check("wide_pre_edge", {28'd0, wbus.out}, 32'd0);
        @(posedge clk);
        #1;
        check("wide_out",   {28'd0, wbus.out},       32'h5);
        check("wide_valid", {31'd0, wbus.out_valid}, 32'd1);
        wbus.en = 1'b0;

        // Reset lands between edges while the registered path holds a 1.
        apply(8'h01, 3'd0, 1'b1, 1'b1, 1'b1, 8'b0000_0001);
        drain();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_out",    {31'd0, mbus.out},        32'd0);
        check("async_valid",  {31'd0, mbus.out_valid},  32'd0);
        check("async_onehot", {24'd0, mbus.sel_onehot}, 32'd0);
        check("async_wide",   {28'd0, wbus.out},        32'd0);

        cbus.in = 8'h5A; cbus.sel = 3'd1; cbus.en = 1'b1;
        #1;
        check("comb_rst_out",    {31'd0, cbus.out},        32'd1);
        check("comb_rst_onehot", {24'd0, cbus.sel_onehot}, 32'h02);
        check("comb_rst_valid",  {31'd0, cbus.out_valid},  32'd0);

        mbus.in = 8'hFF; mbus.sel = 3'd2; mbus.en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_out",   {31'd0, mbus.out},       32'd0);
        check("rst_hold_valid", {31'd0, mbus.out_valid}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        apply(8'h80, 3'd7, 1'b1, 1'b1, 1'b1, 8'b1000_0000);
        drain();

        #1;
        cbus.in = 8'h5A; cbus.sel = 3'd1; cbus.en = 1'b1;
        #1;
        check("comb_sel1_out",    {31'd0, cbus.out},        32'd1);
        check("comb_sel1_onehot", {24'd0, cbus.sel_onehot}, 32'h02);
        check("comb_sel1_valid",  {31'd0, cbus.out_valid},  32'd1);
        cbus.sel = 3'd2;
        #1;
        check("comb_sel2_out",    {31'd0, cbus.out},        32'd0);
        check("comb_sel2_onehot", {24'd0, cbus.sel_onehot}, 32'h04);
        cbus.en = 1'b0;
        #1;
        check("comb_en0_valid", {31'd0, cbus.out_valid}, 32'd0);

        repeat (2) @(posedge clk);
        #2;
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_8x1.md
MUX_8X1 -- requirements
Module: mux_8x1

Interface
REQ-001 Parameter: DATA_W, default 1, bit width of each of the 8 data lanes.
REQ-002 Parameter: REG_OUT, default 1; 1 = registered output path, 0 = combinational output path.
REQ-003 Port: clk  input  1  rising-edge clock; the block has exactly one clock.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in  input  8*DATA_W  eight packed lanes; lane k = in[k*DATA_W +: DATA_W].
REQ-006 Port: sel  input  3  lane select, 0..7.
REQ-007 Port: en  input  1  update enable / input-valid qualifier.
REQ-008 Port: out  output  DATA_W  selected lane.
REQ-009 Port: out_valid  output  1  out holds a lane selected under en=1.
REQ-010 Port: sel_onehot  output  8  one-hot decode of the sel that produced out.

Function
REQ-011 Selection SHALL be lane[sel]; all 8 codes are legal, so there is no out-of-range case.
REQ-012 With DATA_W=1, the selection SHALL equal in[sel].
REQ-013 With REG_OUT=1, on each rising clk edge with en=1: out <= lane[sel], sel_onehot <= 1<<sel, out_valid <= 1.
REQ-014 With REG_OUT=1, latency SHALL be exactly 1 clock.
REQ-015 With REG_OUT=1, on a rising edge with en=0: out and sel_onehot SHALL hold their values, and out_valid <= 0.
REQ-016 With REG_OUT=1, changes on in or sel between edges SHALL NOT affect out.
REQ-017 With REG_OUT=0, out = lane[sel] combinationally and sel_onehot = 1<<sel combinationally, independent of clk.
REQ-018 With REG_OUT=0, out_valid = en.
REQ-019 sel_onehot SHALL have exactly one bit set whenever out_valid=1.
REQ-020 X or Z on sel is not defined behaviour; the bench SHALL drive only known values.

Reset
REQ-021 On rst_n falling, out, sel_onehot and out_valid SHALL go to 0 immediately, without waiting for clk.
REQ-022 While rst_n=0, the registers SHALL hold 0 regardless of en, in or sel.
REQ-023 The first capture after reset release SHALL occur on the first rising clk edge where rst_n=1 and en=1.
REQ-024 With REG_OUT=0, reset SHALL NOT affect out or sel_onehot.
REQ-025 With REG_OUT=0, out_valid SHALL be forced to 0 while rst_n=0.

Verification (DATA_W=1, REG_OUT=1 unless stated)
REQ-026 Exhaustive select: in=8'b1010_0110, en=1, sel stepped 0..7 one per clock -> out sequence 0,1,1,0,0,1,0,1, each value one cycle after its sel.
REQ-027 Random sweep: 20 iterations of random in/sel with en=1 -> every out equals in[sel] from the previous edge, and sel_onehot = 1<<sel.
REQ-028 Hold: capture in=8'hFF, sel=3 (out=1), then set en=0 with in=8'h00 for 3 clocks -> out stays 1, out_valid=0, sel_onehot=8'b0000_1000.
REQ-029 Async reset mid-operation: out=1, out_valid=1, then assert rst_n=0 between edges -> all outputs 0 before the next edge; after release, first en=1 edge with in=8'h80, sel=7 -> out=1.
REQ-030 Combinational mode (REG_OUT=0): in=8'h5A, sel=1 then sel=2 -> out=1 then 0 within the same cycle; out_valid follows en.
REQ-031 Wide lanes (DATA_W=4): in=32'h7654_3210, sel=5 -> out=4'h5 after 1 clock.
